// File: rtl/noc_pkg.sv
// Shared router constants: port count, port-index width and the named port indices.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int PW     = 3;

  localparam logic [PW-1:0] PORT_W  = 3'd0;
  localparam logic [PW-1:0] PORT_E  = 3'd1;
  localparam logic [PW-1:0] PORT_N  = 3'd2;
  localparam logic [PW-1:0] PORT_S  = 3'd3;
  localparam logic [PW-1:0] PORT_PE = 3'd4;

  // Next port index in round-robin order, PE wraps back to W.
  function automatic logic [PW-1:0] port_inc(input logic [PW-1:0] p);
    return (p == PORT_PE) ? PORT_W : p + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb5.sv
// Round-robin arbiter: first requester found scanning from ptr_i upward, modulo N.
module rr_arb5 import noc_pkg::*; #(
  parameter int N = NPORTS,
  parameter int W = PW
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  logic [W:0]   sum;
  logic [W-1:0] cur;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    cur   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      cur = sum[W-1:0];
      if (!vld_o && req_i[cur]) begin
        gnt_o[cur] = 1'b1;
        idx_o      = cur;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_allocator.sv
// 5-port NoC switch allocator: per-output round-robin with optional head-to-tail
// packet locking, enabled by defining SW_ALLOC_PKT_LOCK_EN.
module sw_allocator #(
  parameter int NPORTS = noc_pkg::NPORTS,
  parameter int PW     = noc_pkg::PW
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NPORTS-1:0]    REQ_VALID,
  input  logic [NPORTS*PW-1:0] REQ_OUTPORT,
  input  logic [NPORTS-1:0]    REQ_TAIL,
  input  logic [NPORTS-1:0]    OUT_READY,
  output logic [NPORTS-1:0]    GRANT,
  output logic [NPORTS*PW-1:0] XBAR_SEL,
  output logic [NPORTS-1:0]    XBAR_VALID,
  output logic [NPORTS-1:0]    LOCKED
);

  logic [NPORTS-1:0]             locked_q, locked_d;
  logic [NPORTS-1:0][PW-1:0]     owner_q, owner_d;
  logic [NPORTS-1:0][PW-1:0]     ptr_q, ptr_d;

  logic [NPORTS-1:0][NPORTS-1:0] cand, arb_req, arb_gnt;
  logic [NPORTS-1:0][PW-1:0]     arb_idx;
  logic [NPORTS-1:0]             arb_vld;

  // A locked output only lets its owner through; a stalled output offers nothing.
  always_comb begin
    cand    = '0;
    arb_req = '0;
    for (int o = 0; o < NPORTS; o++) begin
      for (int i = 0; i < NPORTS; i++)
        cand[o][i] = REQ_VALID[i] && (REQ_OUTPORT[i*PW +: PW] == PW'(o));
      if (OUT_READY[o])
        arb_req[o] = locked_q[o] ? (cand[o] & (NPORTS'(1) << owner_q[o])) : cand[o];
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arb5 #(.N(NPORTS), .W(PW)) u_arb (
      .req_i (arb_req[o]),
      .ptr_i (ptr_q[o]),
      .gnt_o (arb_gnt[o]),
      .idx_o (arb_idx[o]),
      .vld_o (arb_vld[o])
    );
  end

  always_comb begin
    GRANT      = '0;
    XBAR_SEL   = '0;
    XBAR_VALID = '0;
    if (!RST) begin
      for (int o = 0; o < NPORTS; o++) begin
        if (arb_vld[o]) begin
          GRANT                = GRANT | arb_gnt[o];
          XBAR_VALID[o]        = 1'b1;
          XBAR_SEL[o*PW +: PW] = arb_idx[o];
        end
      end
    end
  end

  assign LOCKED = RST ? '0 : locked_q;

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    for (int o = 0; o < NPORTS; o++) begin
      if (arb_vld[o]) begin
`ifdef SW_ALLOC_PKT_LOCK_EN
        if (!locked_q[o]) begin
          ptr_d[o] = noc_pkg::port_inc(arb_idx[o]);
          if (!REQ_TAIL[arb_idx[o]]) begin
            locked_d[o] = 1'b1;
            owner_d[o]  = arb_idx[o];
          end
        end else if (REQ_TAIL[arb_idx[o]]) begin
          // Release only; nobody else is granted this output until next cycle.
          locked_d[o] = 1'b0;
        end
`else
        ptr_d[o] = noc_pkg::port_inc(arb_idx[o]);
`endif
      end
    end
  end

`ifndef SW_ALLOC_PKT_LOCK_EN
  logic unused_tail;
  assign unused_tail = ^REQ_TAIL;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      locked_q <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: tb/tb_sw_allocator.sv
// Directed bench for sw_allocator; lock-specific scenarios follow SW_ALLOC_PKT_LOCK_EN.
module tb_sw_allocator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  req_valid;
  logic [14:0] req_outport;
  logic [4:0]  req_tail;
  logic [4:0]  out_ready;
  logic [4:0]  GRANT;
  logic [14:0] XBAR_SEL;
  logic [4:0]  XBAR_VALID;
  logic [4:0]  LOCKED;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  sw_allocator #(.NPORTS(5), .PW(3)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (req_valid),
    .REQ_OUTPORT (req_outport),
    .REQ_TAIL    (req_tail),
    .OUT_READY   (out_ready),
    .GRANT       (GRANT),
    .XBAR_SEL    (XBAR_SEL),
    .XBAR_VALID  (XBAR_VALID),
    .LOCKED      (LOCKED)
  );

  task automatic clr();
    req_valid   = '0;
    req_outport = '0;
    req_tail    = '0;
  endtask

  task automatic req(input int i, input int o, input logic t);
    req_valid[i]         = 1'b1;
    req_outport[i*3 +: 3] = 3'(o);
    req_tail[i]          = t;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clr();
    out_ready = '1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clr();
    out_ready = '1;
    req(0, 2, 1'b1);
    #2;
    checks++; if (GRANT !== 5'b0) begin errors++; $display("FAIL reset_grant: got %b exp 00000", GRANT); end
    checks++; if (XBAR_VALID !== 5'b0) begin errors++; $display("FAIL reset_xvalid: got %b exp 00000", XBAR_VALID); end
    checks++; if (XBAR_SEL !== 15'b0) begin errors++; $display("FAIL reset_xsel: got %h exp 0", XBAR_SEL); end
    checks++; if (LOCKED !== 5'b0) begin errors++; $display("FAIL reset_locked: got %b exp 00000", LOCKED); end
    tick();
  endtask

  task automatic test_two_req();
    do_reset();
    req(0, 2, 1'b1);
    req(1, 2, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL two_req_c1_grant: got %b exp 00001", GRANT); end
    checks++; if (XBAR_SEL[8:6] !== 3'd0) begin errors++; $display("FAIL two_req_c1_sel: got %0d exp 0", XBAR_SEL[8:6]); end
    checks++; if (XBAR_VALID !== 5'b00100) begin errors++; $display("FAIL two_req_c1_xvalid: got %b exp 00100", XBAR_VALID); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    checks++; if (GRANT !== 5'b00010) begin errors++; $display("FAIL two_req_c2_grant: got %b exp 00010", GRANT); end
    checks++; if (XBAR_SEL[8:6] !== 3'd1) begin errors++; $display("FAIL two_req_c2_sel: got %0d exp 1", XBAR_SEL[8:6]); end
    tick();
    clr();
  endtask

  task automatic test_rr_wrap();
    logic [4:0] exp_g;
    do_reset();
    for (int i = 0; i < 5; i++) req(i, 4, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_g = 5'b00001 << (k % 5);
      checks++; if (GRANT !== exp_g) begin errors++; $display("FAIL rr_wrap_grant[%0d]: got %b exp %b", k, GRANT, exp_g); end
      checks++; if (XBAR_SEL[14:12] !== 3'(k % 5)) begin errors++; $display("FAIL rr_wrap_sel[%0d]: got %0d exp %0d", k, XBAR_SEL[14:12], k % 5); end
      tick();
    end
    clr();
  endtask

  task automatic test_invalid_outport();
    do_reset();
    req(2, 6, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b0) begin errors++; $display("FAIL invalid_grant: got %b exp 00000", GRANT); end
    checks++; if (XBAR_VALID !== 5'b0) begin errors++; $display("FAIL invalid_xvalid: got %b exp 00000", XBAR_VALID); end
    checks++; if (LOCKED !== 5'b0) begin errors++; $display("FAIL invalid_locked: got %b exp 00000", LOCKED); end
    tick();
    req(0, 2, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL invalid_after_grant: got %b exp 00001", GRANT); end
    tick();
    clr();
  endtask

  task automatic test_ready_low();
    do_reset();
    out_ready = 5'b11101;
    req(0, 1, 1'b1);
    req(2, 3, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b00100) begin errors++; $display("FAIL ready_low_grant: got %b exp 00100", GRANT); end
    checks++; if (XBAR_VALID !== 5'b01000) begin errors++; $display("FAIL ready_low_xvalid: got %b exp 01000", XBAR_VALID); end
    tick();
    req_valid[2] = 1'b0;
    out_ready = '1;
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL ready_high_grant: got %b exp 00001", GRANT); end
    checks++; if (XBAR_SEL[5:3] !== 3'd0 || XBAR_VALID !== 5'b00010) begin errors++; $display("FAIL ready_high_xbar: got sel %0d valid %b exp sel 0 valid 00010", XBAR_SEL[5:3], XBAR_VALID); end
    tick();
    clr();
  endtask

`ifdef SW_ALLOC_PKT_LOCK_EN
  task automatic test_reset_mid();
    do_reset();
    req(0, 3, 1'b0);
    #1;
    tick();
    checks++; if (LOCKED !== 5'b01000) begin errors++; $display("FAIL rst_mid_locked_before: got %b exp 01000", LOCKED); end
    RST = 1'b1;
    #1;
    checks++; if (LOCKED !== 5'b0) begin errors++; $display("FAIL rst_mid_locked_during: got %b exp 00000", LOCKED); end
    checks++; if (GRANT !== 5'b0) begin errors++; $display("FAIL rst_mid_grant_during: got %b exp 00000", GRANT); end
    RST = 1'b0;
    clr();
    req(1, 3, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b00010) begin errors++; $display("FAIL rst_mid_fresh_grant: got %b exp 00010", GRANT); end
    tick();
    clr();
  endtask

  task automatic test_packet_lock();
    do_reset();
    req(4, 3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      req(0, 3, (k == 2));
      #1;
      checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL pkt_lock_grant[%0d]: got %b exp 00001", k, GRANT); end
      checks++; if (LOCKED[3] !== (k != 0)) begin errors++; $display("FAIL pkt_lock_locked[%0d]: got %b exp %b", k, LOCKED[3], (k != 0)); end
      tick();
    end
    req_valid[0] = 1'b0;
    #1;
    checks++; if (GRANT !== 5'b10000) begin errors++; $display("FAIL pkt_lock_pe_grant: got %b exp 10000", GRANT); end
    checks++; if (LOCKED[3] !== 1'b0) begin errors++; $display("FAIL pkt_lock_released: got %b exp 0", LOCKED[3]); end
    tick();
    clr();
  endtask

  task automatic test_stall();
    do_reset();
    req(0, 1, 1'b0);
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL stall_head_grant: got %b exp 00001", GRANT); end
    tick();
    out_ready[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (GRANT !== 5'b0) begin errors++; $display("FAIL stall_grant[%0d]: got %b exp 00000", k, GRANT); end
      checks++; if (LOCKED[1] !== 1'b1) begin errors++; $display("FAIL stall_locked[%0d]: got %b exp 1", k, LOCKED[1]); end
      tick();
    end
    out_ready = '1;
    req(0, 1, 1'b1);
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL stall_resume_grant: got %b exp 00001", GRANT); end
    tick();
    clr();
    #1;
    checks++; if (LOCKED[1] !== 1'b0) begin errors++; $display("FAIL stall_release: got %b exp 0", LOCKED[1]); end
  endtask
`else
  task automatic test_reset_mid();
    do_reset();
    req(0, 3, 1'b1);
    #1;
    tick();
    req(1, 3, 1'b1);
    RST = 1'b1;
    #1;
    checks++; if (GRANT !== 5'b0) begin errors++; $display("FAIL rst_mid_grant_during: got %b exp 00000", GRANT); end
    checks++; if (XBAR_VALID !== 5'b0) begin errors++; $display("FAIL rst_mid_xvalid_during: got %b exp 00000", XBAR_VALID); end
    RST = 1'b0;
    #1;
    checks++; if (GRANT !== 5'b00001) begin errors++; $display("FAIL rst_mid_fresh_grant: got %b exp 00001", GRANT); end
    tick();
    clr();
  endtask
`endif

  task automatic test_back_to_back();
    int fw;
    int fe;
    logic [4:0] exp_g;
    do_reset();
    fw = 0;
    fe = 0;
    for (int k = 0; k < 4; k++) begin
      clr();
      if (fw < 2) req(0, 2, (fw == 1));
      if (fe < 2) req(1, 2, (fe == 1));
      #1;
`ifdef SW_ALLOC_PKT_LOCK_EN
      exp_g = (k < 2) ? 5'b00001 : 5'b00010;
`else
      exp_g = (k % 2 == 0) ? 5'b00001 : 5'b00010;
`endif
      checks++; if (GRANT !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b exp %b", k, GRANT, exp_g); end
      checks++; if (LOCKED !== 5'b0 && exp_g === 5'b00010 && k == 3) begin errors++; $display("FAIL b2b_locked[%0d]: got %b exp 00000", k, LOCKED); end
      if (exp_g[0]) fw++;
      else fe++;
      tick();
    end
    clr();
    #1;
    checks++; if (LOCKED !== 5'b0) begin errors++; $display("FAIL b2b_final_locked: got %b exp 00000", LOCKED); end
  endtask

  initial begin
    clr();
    out_ready = '1;
    test_reset();
    test_two_req();
    test_rr_wrap();
    test_invalid_outport();
    test_ready_low();
    test_reset_mid();
`ifdef SW_ALLOC_PKT_LOCK_EN
    test_packet_lock();
    test_stall();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
